// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store engine: op codes,
// exception codes, FSM states, the data bus width macro and op decode helpers.
`ifndef MEM_DATA_W
`define MEM_DATA_W 32
`endif

package mem_access_unit_pkg;

  localparam int DATA_W = `MEM_DATA_W;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    EXC_OVERFLOW    = 2'd0,
    EXC_LOAD_ADDR   = 2'd1,
    EXC_STORE_ADDR  = 2'd2,
    EXC_BUS_TIMEOUT = 2'd3
  } exc_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
  endfunction

  // Half-words need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic mis;
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: mis = off[0];
      MEM_OP_LW, MEM_OP_SW:             mis = (off != 2'b00);
      default:                          mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables / lane-replicated write data,
// and little-endian load extraction with sign or zero extension.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]        st_op,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_data,
  output logic [3:0]        st_be,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [3:0]        ld_op,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: pick byte enables and replicate the source into every lane.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    st_be    = 4'hF;
    st_wdata = '0;
    case (st_op)
      MEM_OP_SB: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_OP_SH: begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      MEM_OP_SW: st_wdata = st_data;
      default:   ;
    endcase
  end

  // Load side: select the addressed lane, then extend to the full width.
  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_op)
      MEM_OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_OP_LBU: ld_data = {24'b0, ld_byte};
      MEM_OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_OP_LHU: ld_data = {16'b0, ld_half};
      MEM_OP_LW:  ld_data = ld_rdata;
      default:    ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: accepts one op from EX, runs a req/ack RAM
// transaction for loads/stores, and emits exactly one wb or exc strobe per op.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort a BUS wait after
// TIMEOUT_CYCLES cycles without ram_ack (exception code 3).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [3:0]          ex_mem_op,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic                ex_overflow,
  input  logic                ex_trap_ov,
  input  logic [DATA_W-1:0]   ex_store_data,
  input  logic                flush,
  output logic                ex_ready,
  output logic                stall_req,
  output logic                ram_req,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_addr,
  output logic [3:0]          ram_be,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic                ram_ack,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                wb_valid,
  output logic [DATA_W-1:0]   wb_data,
  output logic                exc_valid,
  output logic [1:0]          exc_code,
  output logic [DATA_W-1:0]   exc_bad_addr
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be at least 1");
  end

  state_e            state_q, state_d;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              kill_q;
  logic              in_bus;
  logic              accept, acc_ov, acc_mis, acc_none, acc_mem;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata, ld_data;
  logic              tmo_hit;

  assign in_bus    = (state_q == ST_BUS);
  assign ex_ready  = ~in_bus;
  assign stall_req = in_bus;

  // RAM outputs are gated by state so an async reset drops them at once.
  assign ram_req   = in_bus;
  assign ram_we    = in_bus & we_q;
  assign ram_addr  = in_bus ? {addr_q[DATA_W-1:2], 2'b00} : '0;
  assign ram_be    = in_bus ? be_q : 4'h0;
  assign ram_wdata = in_bus ? wdata_q : '0;

  mem_align u_align (
    .st_op    (ex_mem_op),
    .st_off   (ex_result[1:0]),
    .st_data  (ex_store_data),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_op    (op_q),
    .ld_off   (addr_q[1:0]),
    .ld_rdata (ram_rdata),
    .ld_data  (ld_data)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = in_bus & ~ram_ack & (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Count BUS cycles spent waiting for ram_ack; restarts on every new access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tmo_cnt_q <= '0;
    else if (!in_bus) tmo_cnt_q <= '0;
    else              tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Accept decode (priority: overflow, misalignment, pass-through, memory) and next state.
  always_comb begin
    accept   = ex_valid & ex_ready & ~flush;
    acc_ov   = 1'b0;
    acc_mis  = 1'b0;
    acc_none = 1'b0;
    acc_mem  = 1'b0;
    state_d  = state_q;
    if (accept) begin
      if (ex_trap_ov & ex_overflow)                   acc_ov   = 1'b1;
      else if (is_misaligned(ex_mem_op, ex_result[1:0])) acc_mis = 1'b1;
      else if (is_load(ex_mem_op) | is_store(ex_mem_op)) acc_mem = 1'b1;
      else                                            acc_none = 1'b1;
    end
    case (state_q)
      ST_BUS: begin
        if (ram_ack)      state_d = ST_RESP;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      default: state_d = acc_mem ? ST_BUS : ST_IDLE;
    endcase
  end

  // Datapath: latch the access, capture load data, and raise one-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= MEM_OP_NONE;
      addr_q       <= '0;
      be_q         <= 4'h0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      kill_q       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      exc_valid    <= 1'b0;
      exc_code     <= EXC_OVERFLOW;
      exc_bad_addr <= '0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      if (acc_ov) begin
        exc_valid    <= 1'b1;
        exc_code     <= EXC_OVERFLOW;
        exc_bad_addr <= '0;
      end else if (acc_mis) begin
        exc_valid    <= 1'b1;
        exc_code     <= is_store(ex_mem_op) ? EXC_STORE_ADDR : EXC_LOAD_ADDR;
        exc_bad_addr <= ex_result;
      end else if (acc_none) begin
        wb_valid <= 1'b1;
        wb_data  <= ex_result;
      end else if (acc_mem) begin
        op_q    <= ex_mem_op;
        addr_q  <= ex_result;
        be_q    <= st_be;
        wdata_q <= st_wdata;
        we_q    <= is_store(ex_mem_op);
        kill_q  <= 1'b0;
      end
      if (in_bus) begin
        // A flush during BUS lets the access finish but silences its result.
        if (flush) kill_q <= 1'b1;
        if (ram_ack) begin
          wb_valid <= ~(kill_q | flush);
          wb_data  <= we_q ? '0 : ld_data;
        end else if (tmo_hit) begin
          exc_valid    <= ~(kill_q | flush);
          exc_code     <= EXC_BUS_TIMEOUT;
          exc_bad_addr <= addr_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_mem_op = 4'd0;
  logic [31:0] ex_result = '0;
  logic        ex_overflow = 1'b0;
  logic        ex_trap_ov = 1'b0;
  logic [31:0] ex_store_data = '0;
  logic        flush = 1'b0;
  logic        ex_ready, stall_req, ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_ack = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        wb_valid, exc_valid;
  logic [31:0] wb_data, exc_bad_addr;
  logic [1:0]  exc_code;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_mem_op     (ex_mem_op),
    .ex_result     (ex_result),
    .ex_overflow   (ex_overflow),
    .ex_trap_ov    (ex_trap_ov),
    .ex_store_data (ex_store_data),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .stall_req     (stall_req),
    .ram_req       (ram_req),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_be        (ram_be),
    .ram_wdata     (ram_wdata),
    .ram_ack       (ram_ack),
    .ram_rdata     (ram_rdata),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .exc_valid     (exc_valid),
    .exc_code      (exc_code),
    .exc_bad_addr  (exc_bad_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op for one cycle; returns at the negedge of the following cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic tov, input logic ov);
    ex_mem_op     = op;
    ex_result     = res;
    ex_store_data = sd;
    ex_trap_ov    = tov;
    ex_overflow   = ov;
    ex_valid      = 1'b1;
    @(negedge clk);
    ex_valid    = 1'b0;
    ex_trap_ov  = 1'b0;
    ex_overflow = 1'b0;
  endtask

  // Zero-wait load: ack in the first BUS cycle, result the cycle after.
  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    issue(op, addr, 32'h0, 1'b0, 1'b0);
    check({tag, "_req"}, {31'b0, ram_req}, 32'd1);
    ram_ack   = 1'b1;
    ram_rdata = rdata;
    @(negedge clk);
    ram_ack = 1'b0;
    check({tag, "_wbv"}, {31'b0, wb_valid}, 32'd1);
    check({tag, "_data"}, wb_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    @(negedge clk);
    check("rst_ready", {31'b0, ex_ready}, 32'd1);
    check("rst_stall", {31'b0, stall_req}, 32'd0);
    check("rst_req", {31'b0, ram_req}, 32'd0);
    check("rst_wbv", {31'b0, wb_valid}, 32'd0);
    check("rst_excv", {31'b0, exc_valid}, 32'd0);
    check("rst_wbdata", wb_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Pass-through op.
    issue(MEM_OP_NONE, 32'h55, 32'h0, 1'b0, 1'b0);
    check("none_wbv", {31'b0, wb_valid}, 32'd1);
    check("none_data", wb_data, 32'h55);
    check("none_excv", {31'b0, exc_valid}, 32'd0);
    @(negedge clk);
    check("none_wbv_pulse", {31'b0, wb_valid}, 32'd0);

    // Trapping add with overflow.
    issue(MEM_OP_NONE, 32'h8000_0000, 32'h0, 1'b1, 1'b1);
    check("ov_excv", {31'b0, exc_valid}, 32'd1);
    check("ov_code", {30'b0, exc_code}, 32'd0);
    check("ov_bad", exc_bad_addr, 32'h0);
    check("ov_wbv", {31'b0, wb_valid}, 32'd0);
    @(negedge clk);
    check("ov_excv_pulse", {31'b0, exc_valid}, 32'd0);

    // LB at 0x1003 with two wait cycles.
    issue(MEM_OP_LB, 32'h0000_1003, 32'h0, 1'b0, 1'b0);
    check("lb_req", {31'b0, ram_req}, 32'd1);
    check("lb_stall1", {31'b0, stall_req}, 32'd1);
    check("lb_addr", ram_addr, 32'h0000_1000);
    check("lb_be", {28'b0, ram_be}, 32'hF);
    check("lb_we", {31'b0, ram_we}, 32'd0);
    @(negedge clk);
    check("lb_stall2", {31'b0, stall_req}, 32'd1);
    @(negedge clk);
    check("lb_stall3", {31'b0, stall_req}, 32'd1);
    check("lb_addr_hold", ram_addr, 32'h0000_1000);
    ram_ack   = 1'b1;
    ram_rdata = 32'h80FF_FF12;
    @(negedge clk);
    ram_ack = 1'b0;
    check("lb_stall_end", {31'b0, stall_req}, 32'd0);
    check("lb_req_drop", {31'b0, ram_req}, 32'd0);
    check("lb_wbv", {31'b0, wb_valid}, 32'd1);
    check("lb_data", wb_data, 32'hFFFF_FF80);
    @(negedge clk);
    check("lb_wbv_pulse", {31'b0, wb_valid}, 32'd0);

    // SH at 0x2002, acked immediately.
    issue(MEM_OP_SH, 32'h0000_2002, 32'h1234_ABCD, 1'b0, 1'b0);
    check("sh_be", {28'b0, ram_be}, 32'hC);
    check("sh_wdata", ram_wdata, 32'hABCD_ABCD);
    check("sh_addr", ram_addr, 32'h0000_2000);
    check("sh_we", {31'b0, ram_we}, 32'd1);
    ram_ack = 1'b1;
    @(negedge clk);
    ram_ack = 1'b0;
    check("sh_wbv", {31'b0, wb_valid}, 32'd1);
    check("sh_data", wb_data, 32'h0);
    check("sh_ready", {31'b0, ex_ready}, 32'd1);

    // SB lane check.
    issue(MEM_OP_SB, 32'h0000_2001, 32'h0000_00A5, 1'b0, 1'b0);
    check("sb_be", {28'b0, ram_be}, 32'h2);
    check("sb_wdata", ram_wdata, 32'hA5A5_A5A5);
    ram_ack = 1'b1;
    @(negedge clk);
    ram_ack = 1'b0;
    check("sb_wbv", {31'b0, wb_valid}, 32'd1);

    // Misaligned LW: exception, never a bus request.
    issue(MEM_OP_LW, 32'h0000_3001, 32'h0, 1'b0, 1'b0);
    check("lwmis_excv", {31'b0, exc_valid}, 32'd1);
    check("lwmis_code", {30'b0, exc_code}, 32'd1);
    check("lwmis_bad", exc_bad_addr, 32'h0000_3001);
    check("lwmis_req", {31'b0, ram_req}, 32'd0);
    check("lwmis_wbv", {31'b0, wb_valid}, 32'd0);
    @(negedge clk);
    check("lwmis_req2", {31'b0, ram_req}, 32'd0);

    // Misaligned SW: store address error.
    issue(MEM_OP_SW, 32'h0000_4002, 32'h0, 1'b0, 1'b0);
    check("swmis_code", {30'b0, exc_code}, 32'd2);
    check("swmis_bad", exc_bad_addr, 32'h0000_4002);

    // Load extension variants.
    do_load("lhu", MEM_OP_LHU, 32'h0000_5002, 32'h89AB_CDEF, 32'h0000_89AB);
    do_load("lh",  MEM_OP_LH,  32'h0000_5000, 32'h1234_8001, 32'hFFFF_8001);
    do_load("lbu", MEM_OP_LBU, 32'h0000_5001, 32'h0000_F700, 32'h0000_00F7);
    do_load("lw",  MEM_OP_LW,  32'h0000_5004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Flush during BUS: access completes, result suppressed.
    issue(MEM_OP_LW, 32'h0000_6000, 32'h0, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_ready_busy", {31'b0, ex_ready}, 32'd0);
    ram_ack   = 1'b1;
    ram_rdata = 32'h1111_2222;
    @(negedge clk);
    ram_ack = 1'b0;
    check("fl_wbv", {31'b0, wb_valid}, 32'd0);
    check("fl_excv", {31'b0, exc_valid}, 32'd0);
    check("fl_ready", {31'b0, ex_ready}, 32'd1);

    // Flush in IDLE ignores ex_valid.
    flush = 1'b1;
    issue(MEM_OP_NONE, 32'h77, 32'h0, 1'b0, 1'b0);
    flush = 1'b0;
    check("fli_wbv", {31'b0, wb_valid}, 32'd0);

    // Stray ack outside BUS.
    ram_ack = 1'b1;
    @(negedge clk);
    ram_ack = 1'b0;
    check("stray_wbv", {31'b0, wb_valid}, 32'd0);
    check("stray_req", {31'b0, ram_req}, 32'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // No ack: BUS for TMO cycles, then timeout exception.
    issue(MEM_OP_LW, 32'h0000_8000, 32'h0, 1'b0, 1'b0);
    repeat (TMO - 1) begin
      check("tmo_req", {31'b0, ram_req}, 32'd1);
      @(negedge clk);
    end
    check("tmo_req_last", {31'b0, ram_req}, 32'd1);
    @(negedge clk);
    check("tmo_excv", {31'b0, exc_valid}, 32'd1);
    check("tmo_code", {30'b0, exc_code}, 32'd3);
    check("tmo_bad", exc_bad_addr, 32'h0000_8000);
    check("tmo_req_drop", {31'b0, ram_req}, 32'd0);
    ram_ack = 1'b1;
    @(negedge clk);
    ram_ack = 1'b0;
    check("tmo_late_ack", {31'b0, wb_valid}, 32'd0);
`else
    // No timeout: BUS waits indefinitely until ack.
    issue(MEM_OP_LW, 32'h0000_8000, 32'h0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("wait_req", {31'b0, ram_req}, 32'd1);
    check("wait_excv", {31'b0, exc_valid}, 32'd0);
    ram_ack   = 1'b1;
    ram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    ram_ack = 1'b0;
    check("wait_data", wb_data, 32'hCAFE_F00D);
`endif

    // Asynchronous reset in the middle of BUS.
    @(negedge clk);
    issue(MEM_OP_LW, 32'h0000_7000, 32'h0, 1'b0, 1'b0);
    check("arst_req_before", {31'b0, ram_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'b0, ram_req}, 32'd0);
    check("arst_ready", {31'b0, ex_ready}, 32'd1);
    ram_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ram_ack = 1'b0;
    check("arst_ready2", {31'b0, ex_ready}, 32'd1);
    check("arst_wbv", {31'b0, wb_valid}, 32'd0);
    check("arst_req2", {31'b0, ram_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine directly downstream of the EX adder.
- Takes the EX result (effective address or ALU value), overflow flag, op code and store data.
- Runs a req/ack transaction to data RAM, aligns and extends load data, and presents one result per op to WB.
- Stalls EX while a RAM access is outstanding. Flags overflow and misaligned-address exceptions.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for ram_ack; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  EX presents an op this cycle
- ex_mem_op  in  4  MEM_OP_* code
- ex_result  in  32  adder result; address for loads/stores, ALU value otherwise
- ex_overflow  in  1  adder overflow flag; meaningful only when ex_trap_ov=1
- ex_trap_ov  in  1  op is a trapping ADD/SUB
- ex_store_data  in  32  store source register
- flush  in  1  kill current/next result
- ex_ready  out  1  op accepted when ex_valid & ex_ready
- stall_req  out  1  equals ~ex_ready
- ram_req  out  1  bus request
- ram_we  out  1  write enable
- ram_addr  out  32  word-aligned address, {ex_result[31:2],2'b00}
- ram_be  out  4  byte enables
- ram_wdata  out  32  lane-replicated store data
- ram_ack  in  1  transfer complete, same-cycle rdata
- ram_rdata  in  32  read data
- wb_valid  out  1  one-cycle result strobe
- wb_data  out  32  result to WB
- exc_valid  out  1  one-cycle exception strobe
- exc_code  out  2  0 overflow, 1 load addr err, 2 store addr err, 3 bus timeout
- exc_bad_addr  out  32  offending address (ex_result); 0 for overflow

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0 except ex_ready=1 and stall_req=0. ram_req drops immediately, mid-transaction included.
- FSM states: IDLE, BUS, RESP.
  - IDLE: ex_ready=1. On accept, evaluate in priority order:
    - ex_trap_ov & ex_overflow: next cycle exc_valid=1, code 0, no bus access, no wb_valid.
    - Misaligned address (half-word with addr[0]=1; word with addr[1:0]!=0): next cycle exc_valid=1, code 1 for loads or 2 for stores, exc_bad_addr=ex_result.
    - MEM_OP_NONE: next cycle wb_valid=1, wb_data=ex_result. Stay in IDLE.
    - Otherwise: latch op, address, byte offset and data; go to BUS.
  - BUS: ex_ready=0. ram_req=1, with addr/we/be/wdata held stable until ram_ack.
    - ram_ack: capture aligned data, drop ram_req the cycle after, go to RESP.
  - RESP: wb_valid=1 for one cycle. Stores also pulse wb_valid, with wb_data=0. Go to IDLE; ex_ready returns in the same cycle.
- Latency:
  - Accept at cycle N gives ram_req at N+1.
  - Ack at N+1 gives wb_valid at N+2, the minimum memory op time.
  - Non-memory ops and exceptions complete at N+1.
- Load alignment (little-endian): byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Store lanes:
  - SB: ram_be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: ram_be=4'b0011<<addr[1:0], wdata={2{data[15:0]}}.
  - SW: ram_be=4'hF.
- Loads drive ram_be=4'hF.
- Flush:
  - In IDLE, ex_valid is ignored that cycle.
  - In BUS, the transaction completes (a store still commits) but wb_valid and exc_valid are suppressed.
  - A pending next-cycle wb_valid/exc_valid is cancelled.
- ram_ack outside BUS is ignored.
- Exactly one of wb_valid/exc_valid may pulse per accepted op.

Optional Feature:
- MEM_ACCESS_TIMEOUT_EN defined:
  - A counter runs in BUS. If TIMEOUT_CYCLES elapse with no ram_ack, drop ram_req, raise exc_valid with code 3 and exc_bad_addr=latched address, then return to IDLE.
  - A late ack is ignored.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- Shared package: MEM_OP_* codes (NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8), EXC_* codes, and the 32-bit data bus width macro used across stages.
- One natural sub-module, mem_align: purely combinational store lane/be generation plus load extraction/extension. The FSM stays in mem_access_unit.

Test Plan:
- LB at 0x1003 with rdata 0x80FF_FF12, ack after 2 wait cycles -> wb_data=0xFFFF_FF80; stall_req high 3 cycles; wb_valid one cycle.
- SH at 0x2002 with data 0x1234_ABCD -> ram_be=4'b1100, ram_wdata=0xABCD_ABCD, ram_addr=0x2000, ram_we=1.
- LW at 0x3001 -> exc_valid at N+1, code 1, exc_bad_addr=0x3001; no ram_req ever.
- Trapping ADD with ex_overflow=1 -> exc_code 0, no wb_valid. MEM_OP_NONE with ex_result=0x55 -> wb_valid at N+1, wb_data=0x55.
- LW in BUS, flush asserted, then ack -> no wb_valid; ex_ready returns after ack. With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no ack -> exc_code 3 after 4 BUS cycles.
- rst pulsed mid-BUS -> ram_req 0 immediately (asynchronous); after release, ex_ready=1 and no stale wb_valid.
